// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder:
//   state_t   - controller states (IDLE, RUN, DONE)
//   N_DEFAULT - default operand width in bits
// ----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add.sv
// ----------------------------------------------------------------------------
// full_add
// One-bit full-adder cell.
// Ports:
//   a, b, c : input bits (c is carry-in)
//   r[1:0]  : r[0] = sum bit, r[1] = carry-out bit
// ----------------------------------------------------------------------------
module full_add (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] r
);

    assign r = {1'b0, a} + {1'b0, b} + {1'b0, c};

endmodule

// File: rtl/serial_add.sv
// ----------------------------------------------------------------------------
// serial_add
// Computes {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock
// through a single full_add cell. A start accepted in IDLE loads the operands;
// N RUN cycles follow, then one DONE cycle with a done pulse.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin an addition (only looked at in IDLE)
//   a, b  : N-bit operands, captured with an accepted start
//   cin   : carry-in, captured with an accepted start
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse, result valid
//   sum   : low N result bits (held until the next accepted start)
//   cout  : result bit N (held until the next accepted start)
// ----------------------------------------------------------------------------
module serial_add
    import serial_add_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_sum_sh;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [1:0]    w_fa_r;
    logic          w_last_bit;

    full_add u_full_add (
        .a (r_a_sh[0]),
        .b (r_b_sh[0]),
        .c (r_carry),
        .r (w_fa_r)
    );

    // The edge processing bit N-1 is the last RUN edge.
    assign w_last_bit = (r_cnt == CW'(N - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_bit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here: no queuing
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry, bit counter, result shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
                    // Result bits enter at the MSB so that after N shifts
                    // bit 0 of the sum sits at bit 0 of the register.
                    r_sum_sh <= {w_fa_r[0], r_sum_sh[N-1:1]};
                    r_carry  <= w_fa_r[1];
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: begin
                    // DONE: hold the result
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum_sh;
    assign cout = r_carry;

endmodule

// File: tb/tb_serial_add.sv
// ----------------------------------------------------------------------------
// tb_serial_add
// Self-checking bench for serial_add (N = 8): directed table vectors,
// hand-written busy-protection and reset-abort sequences, back-to-back
// operation with start held high, and a random run against an arithmetic
// reference model.
// ----------------------------------------------------------------------------
module tb_serial_add;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int tot = 0;
    int bad = 0;

    serial_add #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[4];

    // Reference: plain integer addition, taken modulo 2^(N+1).
    function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return (N+1)'(t % (1 << (N + 1)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tot++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Called at a negedge. Presents operands with start, then keeps garbage
    // on a/b/cin while the addition is in flight. With hold=1 start stays high.
    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                          input logic [N-1:0] es, input logic ec, input bit hold,
                          input string tag);
        int lat;
        lat   = 0;
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        @(negedge clk);
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        for (int e = 1; e <= N + 4; e++) begin
            a   = N'($urandom);
            b   = N'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            if (done) begin
                lat = e;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(N));
        chk({tag, " sum"}, 32'(sum), 32'(es));
        chk({tag, " cout"}, 32'(cout), 32'(ec));
        $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (want %02h/%0d) lat=%0d",
                 tag, va, vb, vc, sum, cout, es, ec, lat);
        @(negedge clk);
        chk({tag, " done drops"}, 32'(done), 32'd0);
        chk({tag, " idle after done"}, 32'(busy), 32'd0);
        chk({tag, " result held"}, 32'({cout, sum}), 32'({ec, es}));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:0] m;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic rc;
        int ndone;
        bit found;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[2] = '{a: 8'h5A, b: 8'h3C, cin: 1'b1, exp_sum: 8'h97, exp_cout: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                   1'b0, $sformatf("vec%0d", i));
        end

        // Busy protection: starts during RUN and in DONE are ignored
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 8'hF0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("busyprot done seen", 32'(found), 32'd1);
        start = 1'b1; a = 8'hF0;
        @(negedge clk);
        start = 1'b0;
        chk("busyprot start in DONE ignored", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busyprot extra done", 32'(ndone), 32'd0);
        chk("busyprot sum", 32'(sum), 32'h02);
        chk("busyprot cout", 32'(cout), 32'd0);
        $display("op busyprot: a=01 b=01 cin=0 -> sum=%02h cout=%0d", sum, cout);

        // Reset in the middle of RUN
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset sum", 32'(sum), 32'd0);
        chk("midreset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset no done", 32'(ndone), 32'd0);
        $display("op midreset: a=AA b=55 aborted, dones=%0d", ndone);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "after_reset");

        // Back-to-back with start held high: one addition every N+2 cycles
        for (int i = 0; i < 12; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            m  = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, m[N-1:0], m[N], 1'b1, $sformatf("b2b%0d", i));
        end
        start = 1'b0;
        @(negedge clk);

        // Random run against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            m  = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, m[N-1:0], m[N], 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
